// File: rtl/register_array_pkg.sv
// Shared types and defaults for the register_array slice.
package register_array_pkg;

  localparam int RA_WIDTH_DEF = 32;
  localparam int RA_DEPTH_DEF = 4;
  localparam int RA_MAX_WIDTH = 256;

  typedef enum logic {
    RA_IDLE,
    RA_SHIFT
  } ra_state_e;

  // Wide enough for any practical WIDTH; users slice the low bits.
  localparam logic [RA_MAX_WIDTH-1:0] RA_Z = {RA_MAX_WIDTH{1'bz}};

endpackage

// File: rtl/register_array_shifter.sv
// Bit-serial shift sequencer: owns the FSM, bit counter and latched word address,
// and tells the array which word to shift on each edge.
module register_array_shifter
  import register_array_pkg::*;
#(
  parameter int WIDTH = RA_WIDTH_DEF,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          shift_start,
  input  logic [AW-1:0] wa,
  output logic          shift_en,
  output logic [AW-1:0] shift_addr,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(WIDTH);

  ra_state_e     state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] lat_addr;

  // The entry edge already shifts, so the array sees the request combinationally.
  assign shift_en   = (state == RA_SHIFT) || shift_start;
  assign shift_addr = (state == RA_SHIFT) ? lat_addr : wa;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RA_IDLE;
      cnt      <= '0;
      lat_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        RA_IDLE: begin
          if (shift_start) begin
            state    <= RA_SHIFT;
            busy     <= 1'b1;
            lat_addr <= wa;
            // Counter starts at WIDTH-1 and decrements on this same edge.
            cnt      <= CW'(WIDTH - 2);
          end
        end
        RA_SHIFT: begin
          if (cnt == '0) begin
            state <= RA_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= RA_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/register_array.sv
// Clocked bank of DEPTH x WIDTH registers with a tri-state read port.
// Optional bit-serial shift engine enabled by defining REGISTER_ARRAY_SERIAL_EN.
module register_array
  import register_array_pkg::*;
#(
  parameter int  WIDTH = RA_WIDTH_DEF,
  parameter int  DEPTH = RA_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [AW-1:0]    WA,
  input  logic             LE,
  input  logic [AW-1:0]    RA,
  input  logic             OE_n,
  output logic [WIDTH-1:0] Q,
  input  logic             SHIFT_START,
  input  logic             SI,
  output logic             SO,
  output logic             BUSY,
  output logic             DONE
);

  logic [WIDTH-1:0] word [DEPTH];
  logic [WIDTH-1:0] rd_data;
  logic             shift_en;
  logic [AW-1:0]    shift_addr;

`ifdef REGISTER_ARRAY_SERIAL_EN
  register_array_shifter #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_shifter (
    .clk         (CLK),
    .rst         (RST),
    .shift_start (SHIFT_START),
    .wa          (WA),
    .shift_en    (shift_en),
    .shift_addr  (shift_addr),
    .busy        (BUSY),
    .done        (DONE)
  );

  assign SO = (BUSY && int'(shift_addr) < DEPTH) ? word[shift_addr][0] : 1'b0;
`else
  assign shift_en   = 1'b0;
  assign shift_addr = '0;
  assign SO         = 1'b0;
  assign BUSY       = 1'b0;
  assign DONE       = 1'b0;

  logic unused_serial;
  assign unused_serial = SHIFT_START;
`endif

  // NOTE: the whole bank is reset because a cleared register set is part of the
  // visible behaviour; this forces flops rather than a RAM macro.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) word[i] <= '0;
    end else begin
      // A load that collides with the word being shifted loses to the shift.
      if (LE && int'(WA) < DEPTH && !(shift_en && WA == shift_addr))
        word[WA] <= A;
      if (shift_en && int'(shift_addr) < DEPTH)
        word[shift_addr] <= {SI, word[shift_addr][WIDTH-1:1]};
    end
  end

  // NOTE: rd_data gets a default before the conditional so no latch is inferred.
  always_comb begin
    rd_data = '0;
    if (int'(RA) < DEPTH) rd_data = word[RA];
  end

  assign Q = OE_n ? RA_Z[WIDTH-1:0] : rd_data;

endmodule

// File: tb/tb_register_array.sv
// Directed self-checking bench for register_array; the serial tests run only
// when REGISTER_ARRAY_SERIAL_EN is defined, otherwise the disabled-engine tests run.
module tb_register_array;

  logic        CLK;
  logic        RST;
  logic [31:0] A;
  logic [1:0]  WA;
  logic        LE;
  logic [1:0]  RA;
  logic        OE_n;
  wire  [31:0] Q;
  logic        SHIFT_START;
  logic        SI;
  logic        SO;
  logic        BUSY;
  logic        DONE;

  int checks   = 0;
  int failures = 0;

  register_array #(.WIDTH(32), .DEPTH(4)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .A           (A),
    .WA          (WA),
    .LE          (LE),
    .RA          (RA),
    .OE_n        (OE_n),
    .Q           (Q),
    .SHIFT_START (SHIFT_START),
    .SI          (SI),
    .SO          (SO),
    .BUSY        (BUSY),
    .DONE        (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic read_check(input string tag, input logic [1:0] ra, input logic [31:0] exp);
    RA = ra;
    #1;
    check(tag, Q, exp);
  endtask

  logic [31:0] model;
  int          done_cnt;
  logic        drove;

  initial begin
    RST = 1'b1; A = '0; WA = '0; LE = 1'b0; RA = '0; OE_n = 1'b0;
    SHIFT_START = 1'b0; SI = 1'b0;
    tick();
    tick();
    RST = 1'b0;

    // Reset state
    for (int i = 0; i < 4; i++) read_check($sformatf("reset_word%0d", i), 2'(i), 32'h0);
    check("reset_busy", 32'(BUSY), 32'h0);
    check("reset_done", 32'(DONE), 32'h0);
    check("reset_so",   32'(SO),   32'h0);

    // Load path, no bypass before the edge
    LE = 1'b1; WA = 2'd2; A = 32'h12345678;
    read_check("no_bypass", 2'd2, 32'h0);
    tick();
    LE = 1'b0;
    read_check("load_word2", 2'd2, 32'h12345678);
    read_check("other_word1", 2'd1, 32'h0);
    A = 32'hAAAAAAAA;
    tick();
    read_check("le0_hold", 2'd2, 32'h12345678);

    // Output disabled: the stored word must not appear on the bus
    OE_n = 1'b1;
    #1;
    drove = (Q === 32'h12345678);
    check("oe_n_release", 32'(drove), 32'h0);
    OE_n = 1'b0;
    #1;

`ifdef REGISTER_ARRAY_SERIAL_EN
    // Serial shift of word1 with SI=1
    LE = 1'b1; WA = 2'd1; A = 32'h87654321;
    tick();
    LE = 1'b0;
    model = 32'h87654321;
    SI = 1'b1; SHIFT_START = 1'b1; WA = 2'd1;
    tick();
    SHIFT_START = 1'b0;
    model = {1'b1, model[31:1]};
    for (int k = 0; k < 32; k++) begin
      if (k < 31) begin
        check($sformatf("shift_busy_%0d", k), 32'(BUSY), 32'h1);
        check($sformatf("shift_so_%0d", k),   32'(SO),   32'(model[0]));
        check($sformatf("shift_done_%0d", k), 32'(DONE), 32'h0);
        tick();
        model = {1'b1, model[31:1]};
      end else begin
        check("shift_end_busy", 32'(BUSY), 32'h0);
        check("shift_end_done", 32'(DONE), 32'h1);
        check("shift_end_so",   32'(SO),   32'h0);
      end
    end
    read_check("shift_result", 2'd1, 32'hFFFFFFFF);
    check("shift_model", model, 32'hFFFFFFFF);
    tick();
    check("done_one_cycle", 32'(DONE), 32'h0);

    // Simultaneous events while shifting word0 with SI=0
    SI = 1'b0; SHIFT_START = 1'b1; WA = 2'd0;
    tick();
    LE = 1'b1; A = 32'h55555555; WA = 2'd0;
    tick();
    SHIFT_START = 1'b0; LE = 1'b1; A = 32'h99999999; WA = 2'd3;
    tick();
    LE = 1'b0; SHIFT_START = 1'b1; WA = 2'd2;
    tick();
    SHIFT_START = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (DONE) done_cnt++;
      tick();
    end
    check("sim_done_once", 32'(done_cnt), 32'h1);
    check("sim_idle", 32'(BUSY), 32'h0);
    read_check("sim_word0_dropped", 2'd0, 32'h0);
    read_check("sim_word3_loaded",  2'd3, 32'h99999999);
    read_check("sim_word2_kept",    2'd2, 32'h12345678);

    // Load and start in the same idle cycle, then reset mid-shift
    SI = 1'b0; SHIFT_START = 1'b1; LE = 1'b1; WA = 2'd1; A = 32'h0;
    tick();
    SHIFT_START = 1'b0; LE = 1'b0;
    read_check("start_beats_load", 2'd1, 32'h7FFFFFFF);
    repeat (9) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rst_mid_busy", 32'(BUSY), 32'h0);
    check("rst_mid_done", 32'(DONE), 32'h0);
    check("rst_mid_so",   32'(SO),   32'h0);
    for (int i = 0; i < 4; i++) read_check($sformatf("rst_mid_word%0d", i), 2'(i), 32'h0);
    SHIFT_START = 1'b1; WA = 2'd2;
    tick();
    SHIFT_START = 1'b0;
    check("restart_busy", 32'(BUSY), 32'h1);
    check("restart_done", 32'(DONE), 32'h0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
`else
    // Engine absent: shift controls are inert, loads are never blocked
    SHIFT_START = 1'b1; WA = 2'd0; SI = 1'b1;
    tick();
    check("noser_busy", 32'(BUSY), 32'h0);
    check("noser_done", 32'(DONE), 32'h0);
    check("noser_so",   32'(SO),   32'h0);
    SHIFT_START = 1'b0;
    tick();
    check("noser_busy2", 32'(BUSY), 32'h0);
    check("noser_done2", 32'(DONE), 32'h0);
    read_check("noser_word0_kept", 2'd0, 32'h0);
    LE = 1'b1; WA = 2'd0; A = 32'hFFFFFFFF;
    tick();
    LE = 1'b0;
    read_check("noser_load_word0", 2'd0, 32'hFFFFFFFF);
    LE = 1'b1; SHIFT_START = 1'b1; WA = 2'd1; A = 32'hCAFEF00D;
    tick();
    LE = 1'b0; SHIFT_START = 1'b0;
    read_check("noser_load_with_start", 2'd1, 32'hCAFEF00D);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
